// File: rtl/three_input_nand_tester_if.sv
// Signal bundle between the NAND self-test initiator (master) and the board/gate side (slave).
// Handshake: start is a level sampled only in IDLE; done is a one-cycle pulse, and results are valid while done=1.
interface three_input_nand_tester_if;
    logic       start;
    logic       d;
    logic       a;
    logic       b;
    logic       c;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [7:0] fail_vec;

    modport master (
        input  start, d,
        output a, b, c, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        output start, d,
        input  a, b, c, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/three_input_nand_tester.sv
// Sweeps all eight {a,b,c} vectors into a three-input NAND, samples d after a settle time
// and records mismatches per vector, with a pass flag and a mismatch count.
module three_input_nand_tester #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    three_input_nand_tester_if.master   bus,
    output logic [1:0]                  state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    state_t        state_q;
    logic [2:0]    vec_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;
    logic          pass_q;
    logic [3:0]    err_q;
    logic [7:0]    fail_q;

    logic          mismatch;
    logic [3:0]    err_d;
    logic [7:0]    fail_d;

    // vec_q drives the gate directly, so {a,b,c} is the vector being checked.
    always_comb begin
        mismatch = (bus.d != ~(&vec_q));
        err_d    = err_q;
        fail_d   = fail_q;
        if (mismatch) begin
            err_d          = err_q + 4'd1;
            fail_d[vec_q]  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= 3'd0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 4'd0;
            fail_q  <= 8'h00;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        vec_q   <= 3'd0;
                        cnt_q   <= '0;
                        err_q   <= 4'd0;
                        fail_q  <= 8'h00;
                        pass_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= SAMPLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                SAMPLE: begin
                    err_q  <= err_d;
                    fail_q <= fail_d;
                    // The final verdict must include the vector-7 sample taken this cycle.
                    if (vec_q == 3'd7) begin
                        pass_q  <= (err_d == 4'd0);
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        vec_q   <= vec_q + 3'd1;
                        cnt_q   <= '0;
                        state_q <= SETTLE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.a         = vec_q[2];
    assign bus.b         = vec_q[1];
    assign bus.c         = vec_q[0];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_vec  = fail_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_three_input_nand_tester.sv
// Bench for three_input_nand_tester: a modelled gate with selectable faults, sweep drivers,
// and a scoreboard of expected {done edge, pass, err_count, fail_vec} per sweep.
module tb_three_input_nand_tester;

  localparam int SC       = 2;
  localparam int PER      = SC + 1;
  localparam int DONE_OFS = 8 * PER;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state;

  three_input_nand_tester_if bus_if();

  three_input_nand_tester #(.SETTLE_CYCLES(SC)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_if),
    .state_o (state)
  );

  // ---------------- clock / reset / edge counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- gate model with faults ----------------
  int         fault_mode;
  logic       vec0_fault;
  logic [2:0] cur_v;
  assign cur_v = {bus_if.a, bus_if.b, bus_if.c};

  always_comb begin
    bus_if.d = ~(&cur_v);
    case (fault_mode)
      1:       bus_if.d = 1'b1;
      2:       bus_if.d = &cur_v;
      3:       bus_if.d = (cur_v == 3'b011) ? 1'b0 : ~(&cur_v);
      default: bus_if.d = ~(&cur_v) ^ (vec0_fault && (cur_v == 3'd0));
    endcase
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [28:0] exp_q[$];
  logic [28:0] mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input int done_edge, input logic [7:0] exp_fail);
    exp_q.push_back({16'(done_edge), (exp_fail == 8'h00), 4'($countones(exp_fail)), exp_fail});
  endtask

  always @(negedge clk) begin
    if (!rst && bus_if.done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'(bus_if.done), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_edge", 32'(cyc - 1), 32'(mon_e[28:13]));
        check("pass",      32'(bus_if.pass), 32'(mon_e[12]));
        check("err_count", 32'(bus_if.err_count), 32'(mon_e[11:8]));
        check("fail_vec",  32'(bus_if.fail_vec), 32'(mon_e[7:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("idle_after_done", {30'd0, state}, 32'd0);
    check("busy_low", 32'(bus_if.busy), 32'd0);
  endtask

  // extra_edge: sweep-relative edge at which a stray start is sampled (0 = none)
  task automatic sweep(input int mode, input logic [7:0] exp_fail, input int extra_edge, input bit abort_v4);
    int e;
    fault_mode = mode;
    @(negedge clk);
    e = cyc;
    bus_if.start = 1'b1;
    if (!abort_v4) push_exp(e + DONE_OFS, exp_fail);
    for (int k = 0; k < DONE_OFS; k++) begin
      @(negedge clk);
      bus_if.start = (k + 1 == extra_edge);
      check("busy_abc", {28'd0, bus_if.busy, cur_v}, {28'd0, 1'b1, 3'(k / PER)});
      if (abort_v4 && k == 4 * PER) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_reset",
              {12'd0, cur_v, bus_if.busy, bus_if.done, bus_if.pass, bus_if.err_count, bus_if.fail_vec, state},
              32'd0);
        repeat (DONE_OFS + 4) @(negedge clk);
        check("abort_no_done", 32'(bus_if.busy), 32'd0);
        return;
      end
    end
    drain();
  endtask

  task automatic held_sweeps();
    int e;
    fault_mode   = 0;
    vec0_fault   = 1'b1;
    @(negedge clk);
    e = cyc;
    bus_if.start = 1'b1;
    push_exp(e + DONE_OFS, 8'h01);
    push_exp(e + DONE_OFS + 2 + DONE_OFS, 8'h00);
    repeat (DONE_OFS + 2) @(negedge clk);
    check("gap_idle", 32'(bus_if.busy), 32'd0);
    vec0_fault = 1'b0;
    @(negedge clk);
    check("reaccept", {20'd0, bus_if.busy, cur_v, bus_if.fail_vec}, {20'd0, 1'b1, 3'd0, 8'h00});
    check("reaccept_err", 32'(bus_if.err_count), 32'd0);
    bus_if.start = 1'b0;
    drain();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst          = 1'b1;
    bus_if.start = 1'b0;
    fault_mode   = 0;
    vec0_fault   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {12'd0, cur_v, bus_if.busy, bus_if.done, bus_if.pass, bus_if.err_count, bus_if.fail_vec, state},
          32'd0);
    rst = 1'b0;
    repeat ($urandom_range(1, 4)) @(negedge clk);

    sweep(0, 8'h00, 0, 1'b0);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    check("results_hold", {23'd0, bus_if.pass, bus_if.fail_vec}, {23'd0, 1'b1, 8'h00});
    sweep(1, 8'h80, 0, 1'b0);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    sweep(2, 8'hFF, 0, 1'b0);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    sweep(3, 8'h08, 5, 1'b0);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    sweep(0, 8'h00, 0, 1'b1);
    sweep(0, 8'h00, 0, 1'b0);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    held_sweeps();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
